reg_load_sequencer: RTL and testbench
=====================================

REG_LOAD_SEQUENCER -- requirements
Module: reg_load_sequencer

Interface
REQ-001 Clock  input  1  single clock; all state updates on its rising edge.
REQ-002 Reset  input  1  reset, asynchronous, active-low; Reset=0 forces the reset state immediately, independent of Clock.
REQ-003 Start  input  1  load request; sampled only in IDLE.
REQ-004 Size  input  2  load width: 00=byte, 01=half (2 bytes), 10=word (4 bytes), 11=reserved, treated as word.
REQ-005 BaseAddr  input  32  byte address of the most significant byte to be loaded.
REQ-006 MemAddr  output  32  byte address presented to memory.
REQ-007 MemRead  output  1  memory read request; held until accepted.
REQ-008 MemData  input  8  memory read data; valid when MemValid=1.
REQ-009 MemValid  input  1  memory response; may rise in the same cycle MemRead rises (combinational memory) or any later cycle.
REQ-010 RegI  output  32  data to the downstream 32-bit register's I input.
REQ-011 RegE  output  1  enable to the downstream register.
REQ-012 RegFunSel  output  3  function select to the downstream register (100=clear and load low byte, 110=shift left 8 and insert low byte).
REQ-013 Busy  output  1  high in every state except IDLE.
REQ-014 Done  output  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WRITE and DONE, and a 2-bit byte index idx.
REQ-016 In IDLE with Start=1, the block SHALL latch Size and BaseAddr, clear idx to 0 and enter REQ; N = 1, 2 or 4 bytes per the latched Size.
REQ-017 In REQ, the block SHALL assert MemRead=1 with MemAddr=latched BaseAddr+idx, computed modulo 2^32 (0xFFFFFFFF+1 wraps to 0x00000000).
REQ-018 In REQ, the block SHALL stay in REQ while MemValid=0; when MemValid=1 it SHALL capture MemData into an internal byte register and enter WRITE.
REQ-019 In WRITE, the block SHALL drive RegE=1, RegI={24'b0, captured byte}, and RegFunSel=100 when idx=0 or 110 when idx>0, for exactly one cycle.
REQ-020 On leaving WRITE, the block SHALL enter DONE when idx=N-1; otherwise it SHALL increment idx and re-enter REQ.
REQ-021 In DONE, the block SHALL assert Done=1 for one cycle, then enter IDLE.
REQ-022 The result SHALL be big-endian: the byte at BaseAddr ends in the most significant loaded byte of the downstream register, and unloaded upper bytes are zero.
REQ-023 With zero-wait memory and Start sampled at edge 0, byte k SHALL occupy REQ in cycle 1+2k and WRITE in cycle 2+2k, and Done SHALL be high in cycle 2N+1.
REQ-024 Each extra cycle of MemValid delay SHALL add exactly one cycle to the total latency.
REQ-025 Start while Busy=1 SHALL be ignored; changes to Size/BaseAddr while busy SHALL have no effect.
REQ-026 MemValid while MemRead=0 SHALL be ignored.
REQ-027 Outside WRITE, RegE SHALL be 0, RegFunSel SHALL be 000 and RegI SHALL be 0.
REQ-028 Outside REQ, MemRead SHALL be 0 and MemAddr SHALL be 0.
REQ-029 Start asserted in the cycle Done is high SHALL be ignored; a new load is accepted on the following cycle, when the block is back in IDLE.

Reset
REQ-030 On Reset=0, the block SHALL enter IDLE and clear idx, the internal byte register and the latched Size/BaseAddr.
REQ-031 All outputs SHALL be 0 during reset and on exit from reset.
REQ-032 Reset mid-operation SHALL abort the load with no further RegE pulse; downstream register contents already written are not restored.

Verification
REQ-033 Word load: BaseAddr=0x100, memory bytes 11,22,33,44 at zero wait -> FunSel sequence 100,110,110,110 on RegE pulses; downstream register reads 0x11223344; Done high in cycle 9.
REQ-034 Half load: BaseAddr=0x20, bytes AB,CD -> downstream register reads 0x0000ABCD; Done high in cycle 5; byte load of 0x7F gives 0x0000007F with Done high in cycle 3.
REQ-035 Wait states: word load with MemValid delayed 3 cycles on byte 2 -> MemRead and MemAddr=BaseAddr+2 held stable throughout; Done high in cycle 12; result unchanged.
REQ-036 Address wrap: word load with BaseAddr=0xFFFFFFFE -> MemAddr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-037 Reset in the WRITE cycle of byte 1 -> outputs 0 immediately, no further RegE pulse, Busy=0; a subsequent Start performs a correct full load.
REQ-038 Start pulsed while busy, and Size=11 -> busy Start ignored (exactly one Done per accepted load); Size=11 behaves as a word load.

Source files
------------

// File: rtl/reg_load_sequencer.sv
// Sequencer that loads a 1/2/4-byte big-endian value from a byte-wide memory
// into a downstream shift register, one byte per REQ/WRITE pair.
module reg_load_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] base_addr,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic [7:0]  mem_data,
  input  logic        mem_valid,
  output logic [31:0] reg_i,
  output logic        reg_e,
  output logic [2:0]  reg_fun_sel,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] FS_NONE         = 3'b000;
  localparam logic [2:0] FS_CLEAR_LOAD   = 3'b100;
  localparam logic [2:0] FS_SHIFT_INSERT = 3'b110;

  state_t      state;
  logic [1:0]  idx;
  logic [1:0]  size_q;
  logic [31:0] base_q;
  logic [7:0]  byte_q;

  // Index of the final byte: byte -> 0, half -> 1, word and reserved -> 3.
  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    case (sz)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

  // The data path only carries the captured byte while the enable is high.
  assign reg_i = reg_e ? {24'h0, byte_q} : 32'h0;

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch below sees the values from before this clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= 2'd0;
      size_q      <= 2'b00;
      base_q      <= 32'h0;
      byte_q      <= 8'h0;
      mem_addr    <= 32'h0;
      mem_read    <= 1'b0;
      reg_e       <= 1'b0;
      reg_fun_sel <= FS_NONE;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_REQ;
            size_q   <= size;
            base_q   <= base_addr;
            idx      <= 2'd0;
            mem_read <= 1'b1;
            mem_addr <= base_addr;
            busy     <= 1'b1;
          end
        end

        S_REQ: begin
          if (mem_valid) begin
            state       <= S_WRITE;
            byte_q      <= mem_data;
            mem_read    <= 1'b0;
            mem_addr    <= 32'h0;
            reg_e       <= 1'b1;
            reg_fun_sel <= (idx == 2'd0) ? FS_CLEAR_LOAD : FS_SHIFT_INSERT;
          end
        end

        S_WRITE: begin
          reg_e       <= 1'b0;
          reg_fun_sel <= FS_NONE;
          if (idx == last_idx(size_q)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state    <= S_REQ;
            idx      <= idx + 2'd1;
            mem_read <= 1'b1;
            // 32-bit add wraps naturally past 0xFFFFFFFF.
            mem_addr <= base_q + {30'd0, idx + 2'd1};
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state       <= S_IDLE;
          mem_read    <= 1'b0;
          mem_addr    <= 32'h0;
          reg_e       <= 1'b0;
          reg_fun_sel <= FS_NONE;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
  a_read_busy:  assert property (@(posedge clk) disable iff (!rst_n) mem_read |-> busy);
  a_exclusive:  assert property (@(posedge clk) disable iff (!rst_n) !(mem_read && reg_e));

endmodule

// File: tb/tb_reg_load_sequencer.sv
// Directed testbench for reg_load_sequencer: byte-wide memory with per-byte
// wait states and a model of the downstream 32-bit shift register.
module tb_reg_load_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] base_addr = 32'h0;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [7:0]  mem_data;
  logic        mem_valid;
  logic [31:0] reg_i;
  logic        reg_e;
  logic [2:0]  reg_fun_sel;
  logic        busy;
  logic        done;

  reg_load_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .size        (size),
    .base_addr   (base_addr),
    .mem_addr    (mem_addr),
    .mem_read    (mem_read),
    .mem_data    (mem_data),
    .mem_valid   (mem_valid),
    .reg_i       (reg_i),
    .reg_e       (reg_e),
    .reg_fun_sel (reg_fun_sel),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Memory model: four bytes starting at cur_base, each with its own wait count.
  logic [7:0]  mem_bytes [4];
  int unsigned delays [4];
  logic [31:0] cur_base = 32'h0;
  logic        spurious = 1'b0;
  int unsigned wcnt = 0;
  logic [1:0]  off;

  assign off       = 2'(mem_addr - cur_base);
  assign mem_data  = spurious ? 8'h5A : mem_bytes[off];
  assign mem_valid = spurious || (mem_read && (wcnt >= delays[off]));

  always @(posedge clk) begin
    if (!mem_read || mem_valid) wcnt <= 0;
    else                        wcnt <= wcnt + 1;
  end

  // Downstream register: 100 clears and loads, 110 shifts left by a byte.
  logic [31:0] dreg = 32'h0;
  always @(posedge clk) begin
    if (reg_e) begin
      case (reg_fun_sel)
        3'b100:  dreg <= {24'h0, reg_i[7:0]};
        3'b110:  dreg <= {dreg[23:0], reg_i[7:0]};
        default: dreg <= 32'hBAD0BAD0;
      endcase
    end
  end

  int errors = 0;
  int checks = 0;

  int          done_cyc;
  int          done_cnt;
  int          viol;
  int          stab_err;
  logic [31:0] addr_q [$];
  logic [2:0]  fsel_q [$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_mem(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    mem_bytes[0] = b0; mem_bytes[1] = b1; mem_bytes[2] = b2; mem_bytes[3] = b3;
    for (int i = 0; i < 4; i++) delays[i] = 0;
  endtask

  // Drives one load and records the observed interface behaviour per cycle.
  // Cycle k is the period after the k-th edge following the edge that samples start.
  task automatic run_load(input logic [1:0] sz, input logic [31:0] base,
                          input bit poke_busy, input bit poke_done, input int budget);
    bit          prev_rd = 1'b0;
    logic [31:0] held = 32'h0;
    addr_q.delete();
    fsel_q.delete();
    done_cyc = -1; done_cnt = 0; viol = 0; stab_err = 0;
    cur_base = base;
    @(negedge clk);
    size = sz; base_addr = base; start = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (mem_read && !prev_rd) begin
        addr_q.push_back(mem_addr);
        held = mem_addr;
      end else if (mem_read && mem_addr !== held) begin
        stab_err++;
      end
      prev_rd = mem_read;
      if (reg_e) fsel_q.push_back(reg_fun_sel);
      else if (reg_i !== 32'h0 || reg_fun_sel !== 3'b000) viol++;
      if (!mem_read && mem_addr !== 32'h0) viol++;
      if (reg_e && mem_read) viol++;
      if (busy !== (done_cnt == 0)) viol++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (poke_busy && k == 3) begin
        start = 1'b1; size = 2'b00; base_addr = 32'hDEAD0000;
      end
      if (poke_busy && k == 4) start = 1'b0;
      if (poke_done) start = done;
    end
    start = 1'b0;
  endtask

  task automatic check_common(input string name, input int exp_done, input logic [31:0] exp_reg,
                              input int n);
    logic [2:0] fs;
    checks++;
    if (done_cyc !== exp_done) begin
      errors++; $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_done);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++; $display("FAIL %s done_count: got %0d expected 1", name, done_cnt);
    end
    checks++;
    if (dreg !== exp_reg) begin
      errors++; $display("FAIL %s result: got %h expected %h", name, dreg, exp_reg);
    end
    checks++;
    if (viol !== 0 || stab_err !== 0) begin
      errors++; $display("FAIL %s idle_outputs: got viol=%0d stab=%0d expected 0/0", name, viol, stab_err);
    end
    checks++;
    if (fsel_q.size() !== n) begin
      errors++; $display("FAIL %s enable_pulses: got %0d expected %0d", name, fsel_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        fs = (i == 0) ? 3'b100 : 3'b110;
        checks++;
        if (fsel_q[i] !== fs) begin
          errors++; $display("FAIL %s funsel[%0d]: got %b expected %b", name, i, fsel_q[i], fs);
        end
      end
    end
  endtask

  task automatic check_addrs(input string name, input logic [31:0] a0, input int n);
    logic [31:0] exp_a;
    checks++;
    if (addr_q.size() !== n) begin
      errors++; $display("FAIL %s addr_count: got %0d expected %0d", name, addr_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_a = a0 + 32'(i);
        checks++;
        if (addr_q[i] !== exp_a) begin
          errors++; $display("FAIL %s addr[%0d]: got %h expected %h", name, i, addr_q[i], exp_a);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_addr, mem_read, reg_i, reg_e, reg_fun_sel, busy, done} !== 71'h0) begin
      errors++; $display("FAIL reset_hold: got outputs nonzero, mem_addr=%h busy=%b", mem_addr, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_addr, mem_read, reg_i, reg_e, reg_fun_sel, busy, done} !== 71'h0) begin
      errors++; $display("FAIL reset_exit: got outputs nonzero, mem_addr=%h busy=%b", mem_addr, busy);
    end
  endtask

  task automatic test_idle_quiet();
    spurious = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, mem_read, reg_e, done} !== 4'b0000) begin
        errors++; $display("FAIL idle_valid: got busy/rd/e/done=%b expected 0000", {busy, mem_read, reg_e, done});
      end
    end
    spurious = 1'b0;
  endtask

  task automatic test_word();
    set_mem(8'h11, 8'h22, 8'h33, 8'h44);
    run_load(2'b10, 32'h100, 1'b0, 1'b0, 13);
    check_common("word", 9, 32'h11223344, 4);
    check_addrs("word", 32'h100, 4);
  endtask

  task automatic test_half_byte();
    set_mem(8'hAB, 8'hCD, 8'hEE, 8'hEE);
    run_load(2'b01, 32'h20, 1'b0, 1'b0, 9);
    check_common("half", 5, 32'h0000ABCD, 2);
    check_addrs("half", 32'h20, 2);
    set_mem(8'h7F, 8'hEE, 8'hEE, 8'hEE);
    run_load(2'b00, 32'h55, 1'b0, 1'b1, 7);
    check_common("byte_done_start", 3, 32'h0000007F, 1);
  endtask

  task automatic test_wait_states();
    set_mem(8'h11, 8'h22, 8'h33, 8'h44);
    delays[2] = 3;
    run_load(2'b10, 32'h100, 1'b0, 1'b0, 16);
    check_common("wait", 12, 32'h11223344, 4);
    check_addrs("wait", 32'h100, 4);
  endtask

  task automatic test_wrap();
    set_mem(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    run_load(2'b10, 32'hFFFFFFFE, 1'b0, 1'b0, 13);
    check_common("wrap", 9, 32'hA1B2C3D4, 4);
    check_addrs("wrap", 32'hFFFFFFFE, 4);
  endtask

  task automatic test_back_to_back();
    set_mem(8'h01, 8'h02, 8'h03, 8'h04);
    run_load(2'b11, 32'h40, 1'b1, 1'b0, 14);
    check_common("busy_start_size11", 9, 32'h01020304, 4);
    check_addrs("busy_start_size11", 32'h40, 4);
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int pulses = 0;
    set_mem(8'h11, 8'h22, 8'h33, 8'h44);
    cur_base = 32'h300;
    @(negedge clk);
    size = 2'b10; base_addr = 32'h300; start = 1'b1;
    for (int k = 1; k <= 10 && !found; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (reg_e && reg_fun_sel == 3'b110) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reset_mid_reach: got no byte-1 write within 10 cycles expected one");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_addr, mem_read, reg_i, reg_e, reg_fun_sel, busy, done} !== 71'h0) begin
      errors++; $display("FAIL reset_mid_async: got reg_e=%b busy=%b expected all outputs 0", reg_e, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (reg_e) pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (reg_e || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", pulses);
    end
    checks++;
    if (dreg !== 32'h00000011) begin
      errors++; $display("FAIL reset_mid_partial: got %h expected 00000011", dreg);
    end
    run_load(2'b10, 32'h300, 1'b0, 1'b0, 13);
    check_common("after_reset", 9, 32'h11223344, 4);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem_bytes[i] = 8'h00;
      delays[i] = 0;
    end
    test_reset();
    test_idle_quiet();
    test_word();
    test_half_byte();
    test_wait_states();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
